// File: rtl/l2_config_and_types.sv
// Shared L2 configuration constants and types.
// Holds port count, arbiter mode and weight-width defaults.
package l2_config_and_types;

  localparam int L2_NUM_PORTS    = 4;
  localparam int L2_ARB_WEIGHT_W = 3;

  typedef enum logic {
    L2_ARB_RR,
    L2_ARB_FIXED
  } l2_arb_mode_t;

  function automatic int l2_idx_w(input int n);
    return (n > 1) ? $clog2(n) : 1;
  endfunction

endpackage

// File: rtl/l2_rr_priority_select.sv
// Rotating find-first-set: picks the first request at or after start.
// Purely combinational; start=0 gives plain lowest-index priority.
module l2_rr_priority_select
  import l2_config_and_types::*;
#(
  parameter int NUM_PORTS = L2_NUM_PORTS,
  parameter int IDX_W     = l2_idx_w(NUM_PORTS)
) (
  input  logic [NUM_PORTS-1:0] req,
  input  logic [IDX_W-1:0]     start,
  output logic [IDX_W-1:0]     idx,
  output logic [NUM_PORTS-1:0] onehot,
  output logic                 valid
);

  logic [NUM_PORTS-1:0] rot;
  logic [IDX_W:0]       sum;
  logic [IDX_W:0]       off;
  logic                 found;

  always_comb begin
    rot   = '0;
    sum   = '0;
    off   = '0;
    found = 1'b0;
    for (int k = 0; k < NUM_PORTS; k++) begin
      sum = {1'b0, start} + (IDX_W+1)'(k);
      if (sum >= (IDX_W+1)'(NUM_PORTS)) begin
        sum = sum - (IDX_W+1)'(NUM_PORTS);
      end
      rot[k] = req[sum[IDX_W-1:0]];
    end
    for (int k = 0; k < NUM_PORTS; k++) begin
      if (!found && rot[k]) begin
        found = 1'b1;
        off   = (IDX_W+1)'(k);
      end
    end
    // Undo the rotation to get the absolute port index.
    sum = {1'b0, start} + off;
    if (sum >= (IDX_W+1)'(NUM_PORTS)) begin
      sum = sum - (IDX_W+1)'(NUM_PORTS);
    end
    valid  = found;
    idx    = found ? sum[IDX_W-1:0] : '0;
    onehot = found ? (NUM_PORTS'(1) << idx) : '0;
  end

endmodule

// File: rtl/l2_weighted_arbiter.sv
// Credit-weighted round-robin / fixed-priority arbiter for L2 request ports.
// A granted port may hold the grant for weight+1 strobed cycles.
module l2_weighted_arbiter
  import l2_config_and_types::*;
#(
  parameter int           NUM_PORTS = L2_NUM_PORTS,
  parameter int           WEIGHT_W  = L2_ARB_WEIGHT_W,
  parameter l2_arb_mode_t MODE      = L2_ARB_RR,
  localparam int          IDX_W     = l2_idx_w(NUM_PORTS)
) (
  input  logic                          clk,
  input  logic                          rst,
  input  logic [NUM_PORTS-1:0]          requests,
  input  logic                          strobe,
  input  logic [NUM_PORTS*WEIGHT_W-1:0] weights,
  output logic [IDX_W-1:0]              grantee_i,
  output logic [NUM_PORTS-1:0]          grantee_v,
  output logic                          grantee_valid,
  output logic                          grantee_last
);

  localparam bit IS_RR = (MODE == L2_ARB_RR);

  logic [IDX_W-1:0]    ptr_q, ptr_d;
  logic [IDX_W-1:0]    owner_q, owner_d;
  logic [WEIGHT_W-1:0] credits_q, credits_d;

  logic [WEIGHT_W-1:0] w_arr [NUM_PORTS];
  logic [IDX_W-1:0]    start;
  logic [IDX_W-1:0]    sel_idx;
  logic [NUM_PORTS-1:0] sel_oh;
  logic                sel_vld;
  logic                sticky;
  logic                gnt_vld;
  logic [IDX_W-1:0]    gnt_idx;

  always_comb begin
    for (int p = 0; p < NUM_PORTS; p++) begin
      w_arr[p] = weights[p*WEIGHT_W +: WEIGHT_W];
    end
  end

  always_comb begin
    start = '0;
    if (IS_RR && ptr_q != IDX_W'(NUM_PORTS-1)) begin
      start = ptr_q + IDX_W'(1);
    end
  end

  l2_rr_priority_select #(
    .NUM_PORTS (NUM_PORTS),
    .IDX_W     (IDX_W)
  ) u_sel (
    .req    (requests),
    .start  (start),
    .idx    (sel_idx),
    .onehot (sel_oh),
    .valid  (sel_vld)
  );

  // Outputs stay at their idle values while reset is held.
  always_comb begin
    gnt_vld = rst && sel_vld;
    sticky  = IS_RR && gnt_vld &&
              (credits_q != '0) && requests[owner_q];
    gnt_idx = sticky ? owner_q : sel_idx;

    grantee_valid = gnt_vld;
    grantee_i     = gnt_vld ? gnt_idx : '0;
    grantee_v     = '0;
    grantee_last  = 1'b0;
    if (gnt_vld) begin
      grantee_v = sticky ? (NUM_PORTS'(1) << owner_q) : sel_oh;
      if (!IS_RR) begin
        grantee_last = 1'b1;
      end else if (sticky) begin
        grantee_last = (credits_q == WEIGHT_W'(1));
      end else begin
        grantee_last = (w_arr[sel_idx] == '0);
      end
    end
  end

  always_comb begin
    ptr_d     = ptr_q;
    owner_d   = owner_q;
    credits_d = credits_q;
    if (IS_RR && strobe && gnt_vld) begin
      if (sticky) begin
        credits_d = credits_q - WEIGHT_W'(1);
      end else begin
        owner_d   = sel_idx;
        ptr_d     = sel_idx;
        credits_d = w_arr[sel_idx];
      end
    end
  end

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      ptr_q     <= IDX_W'(NUM_PORTS-1);
      owner_q   <= '0;
      credits_q <= '0;
    end else begin
      ptr_q     <= ptr_d;
      owner_q   <= owner_d;
      credits_q <= credits_d;
    end
  end

endmodule

// File: tb/tb_l2_weighted_arbiter.sv
// Directed bench for l2_weighted_arbiter: RR and FIXED instances, 4 ports.
// Inputs change on the falling edge; outputs are checked 1ns later.
module tb_l2_weighted_arbiter;
  import l2_config_and_types::*;

  logic        clk;
  logic        rst;
  logic [3:0]  requests;
  logic        strobe;
  logic [11:0] weights;

  logic [1:0]  g_i, f_i;
  logic [3:0]  g_v, f_v;
  logic        g_vld, f_vld;
  logic        g_last, f_last;

  int tests;
  int fails;

  l2_weighted_arbiter #(
    .NUM_PORTS (4),
    .WEIGHT_W  (3),
    .MODE      (L2_ARB_RR)
  ) u_rr (
    .clk           (clk),
    .rst           (rst),
    .requests      (requests),
    .strobe        (strobe),
    .weights       (weights),
    .grantee_i     (g_i),
    .grantee_v     (g_v),
    .grantee_valid (g_vld),
    .grantee_last  (g_last)
  );

  l2_weighted_arbiter #(
    .NUM_PORTS (4),
    .WEIGHT_W  (3),
    .MODE      (L2_ARB_FIXED)
  ) u_fix (
    .clk           (clk),
    .rst           (rst),
    .requests      (requests),
    .strobe        (strobe),
    .weights       (weights),
    .grantee_i     (f_i),
    .grantee_v     (f_v),
    .grantee_valid (f_vld),
    .grantee_last  (f_last)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic chk(input string tag, input logic [1:0] ei,
                     input logic [3:0] ev, input logic evld,
                     input logic elast, input bit fix);
    logic [1:0] ai;
    logic [3:0] av;
    logic       avld, alast;
    ai    = fix ? f_i : g_i;
    av    = fix ? f_v : g_v;
    avld  = fix ? f_vld : g_vld;
    alast = fix ? f_last : g_last;
    tests++;
    assert (ai === ei) else begin
      fails++;
      $error("FAIL %s grantee_i got %0d exp %0d", tag, ai, ei);
    end
    tests++;
    assert (av === ev) else begin
      fails++;
      $error("FAIL %s grantee_v got %b exp %b", tag, av, ev);
    end
    tests++;
    assert (avld === evld) else begin
      fails++;
      $error("FAIL %s grantee_valid got %b exp %b", tag, avld, evld);
    end
    tests++;
    assert (alast === elast) else begin
      fails++;
      $error("FAIL %s grantee_last got %b exp %b", tag, alast, elast);
    end
  endtask

  task automatic drive(input logic [3:0] rq, input logic st);
    @(negedge clk);
    requests = rq;
    strobe   = st;
    #1;
  endtask

  task automatic do_reset();
    @(negedge clk);
    strobe = 1'b0;
    rst    = 1'b0;
    #2;
    rst    = 1'b1;
  endtask

  initial begin
    tests    = 0;
    fails    = 0;
    rst      = 1'b0;
    requests = 4'b1111;
    strobe   = 1'b1;
    weights  = '0;

    // Reset held: outputs idle despite requests
    repeat (2) @(negedge clk);
    #1;
    chk("rst_rr", 2'd0, 4'b0000, 1'b0, 1'b0, 1'b0);
    chk("rst_fix", 2'd0, 4'b0000, 1'b0, 1'b0, 1'b1);

    @(negedge clk);
    rst      = 1'b1;
    requests = 4'b0000;
    strobe   = 1'b0;
    #1;
    chk("idle", 2'd0, 4'b0000, 1'b0, 1'b0, 1'b0);

    // Plain RR, all weights 0
    weights = '0;
    drive(4'b1111, 1'b1); chk("rr0", 2'd0, 4'b0001, 1, 1, 0);
    drive(4'b1111, 1'b1); chk("rr1", 2'd1, 4'b0010, 1, 1, 0);
    drive(4'b1111, 1'b1); chk("rr2", 2'd2, 4'b0100, 1, 1, 0);
    drive(4'b1111, 1'b1); chk("rr3", 2'd3, 4'b1000, 1, 1, 0);
    drive(4'b1111, 1'b1); chk("rr4", 2'd0, 4'b0001, 1, 1, 0);

    // Weighted burst: port 1 weight 2
    do_reset();
    weights = {3'd0, 3'd0, 3'd2, 3'd0};
    drive(4'b1111, 1'b1); chk("wb0", 2'd0, 4'b0001, 1, 1, 0);
    drive(4'b1111, 1'b1); chk("wb1", 2'd1, 4'b0010, 1, 0, 0);
    drive(4'b1111, 1'b1); chk("wb2", 2'd1, 4'b0010, 1, 0, 0);
    drive(4'b1111, 1'b1); chk("wb3", 2'd1, 4'b0010, 1, 1, 0);
    drive(4'b1111, 1'b1); chk("wb4", 2'd2, 4'b0100, 1, 1, 0);
    drive(4'b1111, 1'b1); chk("wb5", 2'd3, 4'b1000, 1, 1, 0);

    // Owner drop: port 1 weight 3, port 2 weight 1
    do_reset();
    weights = {3'd0, 3'd1, 3'd3, 3'd0};
    drive(4'b1111, 1'b1); chk("od0", 2'd0, 4'b0001, 1, 1, 0);
    drive(4'b1111, 1'b1); chk("od1", 2'd1, 4'b0010, 1, 0, 0);
    drive(4'b1111, 1'b1); chk("od2", 2'd1, 4'b0010, 1, 0, 0);
    drive(4'b1101, 1'b1); chk("od_drop", 2'd2, 4'b0100, 1, 0, 0);
    drive(4'b0000, 1'b1); chk("od_idle", 2'd0, 4'b0000, 0, 0, 0);
    drive(4'b1111, 1'b0); chk("od_hold", 2'd2, 4'b0100, 1, 1, 0);
    drive(4'b1111, 1'b1); chk("od_hold2", 2'd2, 4'b0100, 1, 1, 0);
    drive(4'b1111, 1'b1); chk("od_next", 2'd3, 4'b1000, 1, 1, 0);

    // Fixed mode: lowest index wins regardless of weights
    do_reset();
    weights = {3'd7, 3'd7, 3'd7, 3'd7};
    for (int c = 0; c < 5; c++) begin
      drive(4'b1010, 1'b1);
      chk("fix", 2'd1, 4'b0010, 1, 1, 1);
    end
    drive(4'b0000, 1'b1); chk("fix_idle", 2'd0, 4'b0000, 0, 0, 1);

    // Async reset in the middle of a port-2 burst
    do_reset();
    weights = {3'd0, 3'd7, 3'd0, 3'd0};
    drive(4'b0100, 1'b1); chk("ar0", 2'd2, 4'b0100, 1, 0, 0);
    drive(4'b0100, 1'b1); chk("ar1", 2'd2, 4'b0100, 1, 0, 0);
    drive(4'b1111, 1'b1); chk("ar2", 2'd2, 4'b0100, 1, 0, 0);
    #2;
    rst = 1'b0;
    #1;
    chk("ar_rst", 2'd0, 4'b0000, 0, 0, 0);
    @(negedge clk);
    rst      = 1'b1;
    requests = 4'b1111;
    strobe   = 1'b0;
    #1;
    chk("ar_rel", 2'd0, 4'b0001, 1, 1, 0);

    $display("[TB] %0d tests run, %0d failed", tests, fails);
    $finish;
  end

endmodule
